// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: opcode bit indices, load
// encodings, the long-latency queue entry and the load-extension helper.
package wb_pkg;

  localparam int OPI_JAL  = 9;
  localparam int OPI_LOAD = 8;

  // Entry data is sized for the widest supported XLEN.
  localparam int WB_DATA_MAX = 64;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef struct packed {
    logic [4:0]             rd;
    logic [WB_DATA_MAX-1:0] data;
  } ll_entry_t;

  // Extends at 64 bits; a 32-bit datapath truncates, so ld and lwu collapse to lw.
  function automatic logic [63:0] load_extend(input logic [2:0] funct3,
                                              input logic [63:0] md);
    logic [63:0] r;
    case (funct3)
      F3_LB:   r = {{56{md[7]}}, md[7:0]};
      F3_LH:   r = {{48{md[15]}}, md[15:0]};
      F3_LW:   r = {{32{md[31]}}, md[31:0]};
      F3_LD:   r = md;
      F3_LBU:  r = {56'b0, md[7:0]};
      F3_LHU:  r = {48'b0, md[15:0]};
      F3_LWU:  r = {32'b0, md[31:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Circular-buffer FIFO holding accepted long-latency results until a free
// write-port slot drains them; wrapping pointers plus an explicit count.
module wb_ll_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_i,
  input  logic [W-1:0]  enq_data_i,
  input  logic          deq_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;

  // NOTE: every always_comb output is a plain function of its inputs with no
  // hold path, so no latch can be inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(enq_i);
    rd_ptr_d = rd_ptr_q + PW'(deq_i);
    count_d  = count_q + CW'(enq_i) - CW'(deq_i);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never observed and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (enq_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/write_back_arb.sv
// Write-back stage: shares one register-file write port between the regW
// pipeline result and queued long-latency results; counts retired instructions.
module write_back_arb
  import wb_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 4,
  parameter int NUM_LL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   regW_i_valid,
  input  logic [11:0]            regW_i_opcode_info,
  input  logic [2:0]             regW_i_funct3,
  input  logic [XLEN-1:0]        regW_i_alu_result,
  input  logic [XLEN-1:0]        regW_i_memdata,
  input  logic [XLEN-1:0]        regW_i_pc,
  input  logic [4:0]             regW_i_rd,
  input  logic                   regW_i_reg_wen,
  input  logic [NUM_LL-1:0]      ll_i_valid,
  input  logic [NUM_LL*5-1:0]    ll_i_rd,
  input  logic [NUM_LL*XLEN-1:0] ll_i_data,
  output logic [NUM_LL-1:0]      ll_o_ready,
  output logic [4:0]             write_back_o_rd,
  output logic [XLEN-1:0]        write_back_o_data,
  output logic                   write_back_o_reg_wen,
  output logic                   write_back_o_stall,
  output logic [63:0]            write_back_o_instret
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]     load_ext;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_req;
  ll_entry_t       enq_entry, head_entry;
  logic            enq, deq;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;
  logic [63:0]     instret_d, instret_q;

  always_comb begin
    load_ext  = load_extend(regW_i_funct3, 64'(regW_i_memdata));
    pipe_data = regW_i_alu_result;
    if (regW_i_opcode_info[OPI_JAL])       pipe_data = regW_i_pc + XLEN'(4);
    else if (regW_i_opcode_info[OPI_LOAD]) pipe_data = load_ext[XLEN-1:0];
  end

  assign pipe_req = regW_i_valid & regW_i_reg_wen & (regW_i_rd != 5'd0);

  // A full queue owns the port and holds regW until a slot frees.
  always_comb begin
    write_back_o_stall   = 1'b0;
    write_back_o_reg_wen = 1'b0;
    write_back_o_rd      = '0;
    write_back_o_data    = '0;
    deq                  = 1'b0;
    if (!rst) begin
      if (fifo_full || (!pipe_req && !fifo_empty)) begin
        write_back_o_stall   = fifo_full;
        write_back_o_reg_wen = 1'b1;
        write_back_o_rd      = head_entry.rd;
        write_back_o_data    = XLEN'(head_entry.data);
        deq                  = 1'b1;
      end else if (pipe_req) begin
        write_back_o_reg_wen = 1'b1;
        write_back_o_rd      = regW_i_rd;
        write_back_o_data    = pipe_data;
      end
    end
  end

  // Lowest set valid bit wins; ready looks only at the registered count.
  always_comb begin
    ll_o_ready = '0;
    acc_rd     = '0;
    acc_data   = '0;
    if (!rst && fifo_count != CW'(DEPTH))
      ll_o_ready = ll_i_valid & (~ll_i_valid + NUM_LL'(1));
    for (int k = 0; k < NUM_LL; k++) begin
      if (ll_o_ready[k]) begin
        acc_rd   = ll_i_rd[5*k +: 5];
        acc_data = ll_i_data[XLEN*k +: XLEN];
      end
    end
    enq            = (|ll_o_ready) && (acc_rd != 5'd0);
    enq_entry.rd   = acc_rd;
    enq_entry.data = WB_DATA_MAX'(acc_data);
  end

  wb_ll_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(ll_entry_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (enq),
    .enq_data_i (enq_entry),
    .deq_i      (deq),
    .head_o     (head_entry),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb instret_d = instret_q + 64'(regW_i_valid & ~write_back_o_stall);

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign write_back_o_instret = instret_q;

endmodule

// File: tb/tb_write_back_arb.sv
// Self-checking bench for write_back_arb: directed scenarios plus randomized
// traffic against a queue-based reference model of the write-back rules.
module tb_write_back_arb;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 4;
  localparam int NUM_LL = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   regW_i_valid;
  logic [11:0]            regW_i_opcode_info;
  logic [2:0]             regW_i_funct3;
  logic [XLEN-1:0]        regW_i_alu_result;
  logic [XLEN-1:0]        regW_i_memdata;
  logic [XLEN-1:0]        regW_i_pc;
  logic [4:0]             regW_i_rd;
  logic                   regW_i_reg_wen;
  logic [NUM_LL-1:0]      ll_i_valid;
  logic [NUM_LL*5-1:0]    ll_i_rd;
  logic [NUM_LL*XLEN-1:0] ll_i_data;
  logic [NUM_LL-1:0]      ll_o_ready;
  logic [4:0]             wb_rd;
  logic [XLEN-1:0]        wb_data;
  logic                   wb_wen;
  logic                   wb_stall;
  logic [63:0]            wb_instret;

  always #5 clk = ~clk;

  write_back_arb #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_LL(NUM_LL)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .regW_i_valid         (regW_i_valid),
    .regW_i_opcode_info   (regW_i_opcode_info),
    .regW_i_funct3        (regW_i_funct3),
    .regW_i_alu_result    (regW_i_alu_result),
    .regW_i_memdata       (regW_i_memdata),
    .regW_i_pc            (regW_i_pc),
    .regW_i_rd            (regW_i_rd),
    .regW_i_reg_wen       (regW_i_reg_wen),
    .ll_i_valid           (ll_i_valid),
    .ll_i_rd              (ll_i_rd),
    .ll_i_data            (ll_i_data),
    .ll_o_ready           (ll_o_ready),
    .write_back_o_rd      (wb_rd),
    .write_back_o_data    (wb_data),
    .write_back_o_reg_wen (wb_wen),
    .write_back_o_stall   (wb_stall),
    .write_back_o_instret (wb_instret)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queued results in acceptance order plus a retire count.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t              mq[$];
  logic [63:0]       m_instret = '0;
  logic              e_wen, e_stall, m_deq, m_acc;
  logic [4:0]        e_rd, m_acc_rd;
  logic [63:0]       e_data, m_acc_data;
  logic [NUM_LL-1:0] e_ready;

  function automatic logic [63:0] ref_pipe_data();
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [63:0]        md;
    md = regW_i_memdata;
    b  = md[7:0];
    h  = md[15:0];
    w  = md[31:0];
    if (regW_i_opcode_info[9]) return regW_i_pc + 64'd4;
    if (regW_i_opcode_info[8]) begin
      case (regW_i_funct3)
        3'd0:    return 64'(b);
        3'd1:    return 64'(h);
        3'd2:    return 64'(w);
        3'd3:    return md;
        3'd4:    return md & 64'hFF;
        3'd5:    return md & 64'hFFFF;
        3'd6:    return md & 64'hFFFF_FFFF;
        default: return 64'd0;
      endcase
    end
    return regW_i_alu_result;
  endfunction

  function automatic void model_eval();
    logic full, req;
    full    = (mq.size() == DEPTH);
    req     = regW_i_valid && regW_i_reg_wen && (regW_i_rd != 0);
    e_wen   = 1'b0;
    e_stall = 1'b0;
    e_rd    = '0;
    e_data  = '0;
    e_ready = '0;
    m_deq   = 1'b0;
    m_acc   = 1'b0;
    m_acc_rd   = '0;
    m_acc_data = '0;
    if (rst) return;
    e_stall = full;
    if (full || (!req && mq.size() > 0)) begin
      e_wen = 1'b1; e_rd = mq[0].rd; e_data = mq[0].data; m_deq = 1'b1;
    end else if (req) begin
      e_wen = 1'b1; e_rd = regW_i_rd; e_data = ref_pipe_data();
    end
    if (!full) begin
      for (int k = 0; k < NUM_LL; k++) begin
        if (ll_i_valid[k] && !m_acc) begin
          e_ready[k] = 1'b1;
          m_acc      = 1'b1;
          m_acc_rd   = ll_i_rd[5*k +: 5];
          m_acc_data = ll_i_data[XLEN*k +: XLEN];
        end
      end
    end
  endfunction

  function automatic void model_commit();
    ent_t e;
    if (rst) begin
      mq.delete();
      m_instret = '0;
      return;
    end
    if (m_deq) void'(mq.pop_front());
    if (m_acc && m_acc_rd != 0) begin
      e.rd = m_acc_rd; e.data = m_acc_data;
      mq.push_back(e);
    end
    if (regW_i_valid && !e_stall) m_instret = m_instret + 64'd1;
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    regW_i_valid       = 1'b0;
    regW_i_opcode_info = '0;
    regW_i_funct3      = '0;
    regW_i_alu_result  = '0;
    regW_i_memdata     = '0;
    regW_i_pc          = '0;
    regW_i_rd          = '0;
    regW_i_reg_wen     = 1'b0;
    ll_i_valid         = '0;
    ll_i_rd            = '0;
    ll_i_data          = '0;
  endtask

  task automatic set_pipe(input logic [11:0] op, input logic [2:0] f3,
                          input logic [63:0] alu, input logic [63:0] md,
                          input logic [63:0] pc, input logic [4:0] rd);
    regW_i_valid       = 1'b1;
    regW_i_opcode_info = op;
    regW_i_funct3      = f3;
    regW_i_alu_result  = alu;
    regW_i_memdata     = md;
    regW_i_pc          = pc;
    regW_i_rd          = rd;
    regW_i_reg_wen     = 1'b1;
  endtask

  task automatic set_ll(input int k, input logic v, input logic [4:0] rd,
                        input logic [63:0] data);
    ll_i_valid[k]             = v;
    ll_i_rd[5*k +: 5]         = rd;
    ll_i_data[XLEN*k +: XLEN] = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_pipe(12'h000, 3'd0, 64'h1234, 64'h0, 64'h0, 5'd3);
    ll_i_valid = 2'b11;
    settle();
    n_cmp++; if (wb_wen !== 1'b0) begin n_bad++; $display("FAIL rst_wen: got %b want 0", wb_wen); end
    n_cmp++; if (ll_o_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b want 00", ll_o_ready); end
    n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", wb_stall); end
    tick(); settle(); tick();
    rst = 1'b0;
    clear_inputs();
    settle();
    n_cmp++; if (wb_instret !== 64'd0) begin n_bad++; $display("FAIL rst_instret: got %0d want 0", wb_instret); end
    n_cmp++; if (wb_wen !== 1'b0) begin n_bad++; $display("FAIL idle_wen: got %b want 0", wb_wen); end
    n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall: got %b want 0", wb_stall); end
    tick();
  endtask

  task automatic test_load_ext();
    clear_inputs();
    set_pipe(12'h100, 3'd0, 64'hDEAD, 64'h80, 64'h0, 5'd5);
    settle();
    n_cmp++; if (wb_data !== 64'hFFFF_FFFF_FFFF_FF80) begin n_bad++; $display("FAIL lb_data: got %h want ffffffffffffff80", wb_data); end
    n_cmp++; if (wb_wen !== 1'b1 || wb_rd !== 5'd5) begin n_bad++; $display("FAIL lb_port: got wen=%b rd=%0d want wen=1 rd=5", wb_wen, wb_rd); end
    tick();
    set_pipe(12'h100, 3'd5, 64'hDEAD, 64'hFFFF8001, 64'h0, 5'd6);
    settle();
    n_cmp++; if (wb_data !== 64'h8001) begin n_bad++; $display("FAIL lhu_data: got %h want 8001", wb_data); end
    tick();
    set_pipe(12'h100, 3'd7, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd6);
    settle();
    n_cmp++; if (wb_data !== 64'h0) begin n_bad++; $display("FAIL f3_7_data: got %h want 0", wb_data); end
    tick();
  endtask

  task automatic test_jal();
    clear_inputs();
    set_pipe(12'h200, 3'd0, 64'hDEAD, 64'h0, 64'h8000_0000, 5'd1);
    settle();
    n_cmp++; if (wb_data !== 64'h8000_0004 || wb_rd !== 5'd1) begin n_bad++; $display("FAIL jal_data: got %h rd=%0d want 80000004 rd=1", wb_data, wb_rd); end
    tick();
    set_pipe(12'h200, 3'd0, 64'hDEAD, 64'h0, 64'h8000_0000, 5'd0);
    settle();
    n_cmp++; if (wb_wen !== 1'b0) begin n_bad++; $display("FAIL jal_x0_wen: got %b want 0", wb_wen); end
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (wb_instret !== m_instret) begin n_bad++; $display("FAIL jal_x0_instret: got %0d want %0d", wb_instret, m_instret); end
    tick();
  endtask

  task automatic test_collision();
    clear_inputs();
    set_pipe(12'h000, 3'd0, 64'hA1, 64'h0, 64'h0, 5'd3);
    set_ll(0, 1'b1, 5'd7, 64'h7777);
    set_ll(1, 1'b1, 5'd8, 64'h8888);
    settle();
    n_cmp++; if (ll_o_ready !== 2'b01) begin n_bad++; $display("FAIL col_ready0: got %b want 01", ll_o_ready); end
    n_cmp++; if (wb_rd !== 5'd3 || wb_data !== 64'hA1) begin n_bad++; $display("FAIL col_pipe: got rd=%0d data=%h want rd=3 data=a1", wb_rd, wb_data); end
    tick();
    set_ll(0, 1'b0, 5'd0, 64'h0);
    settle();
    n_cmp++; if (ll_o_ready !== 2'b10) begin n_bad++; $display("FAIL col_ready1: got %b want 10", ll_o_ready); end
    n_cmp++; if (wb_rd !== 5'd3) begin n_bad++; $display("FAIL col_pipe2: got rd=%0d want 3", wb_rd); end
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (wb_wen !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'h7777) begin n_bad++; $display("FAIL col_ch0: got wen=%b rd=%0d data=%h want 1/7/7777", wb_wen, wb_rd, wb_data); end
    tick(); settle();
    n_cmp++; if (wb_wen !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 64'h8888) begin n_bad++; $display("FAIL col_ch1: got wen=%b rd=%0d data=%h want 1/8/8888", wb_wen, wb_rd, wb_data); end
    tick(); settle();
    n_cmp++; if (wb_wen !== 1'b0) begin n_bad++; $display("FAIL col_empty: got %b want 0", wb_wen); end
    tick();
  endtask

  task automatic test_fill();
    logic [63:0] snap;
    clear_inputs();
    set_pipe(12'h000, 3'd0, 64'h55, 64'h0, 64'h0, 5'd10);
    for (int i = 0; i < DEPTH; i++) begin
      set_ll(0, 1'b1, 5'(11 + i), 64'(32'hF000 + i));
      settle();
      n_cmp++; if (ll_o_ready !== 2'b01 || wb_rd !== 5'd10 || wb_stall !== 1'b0) begin n_bad++; $display("FAIL fill_%0d: got ready=%b rd=%0d stall=%b want 01/10/0", i, ll_o_ready, wb_rd, wb_stall); end
      tick();
    end
    set_ll(0, 1'b1, 5'd20, 64'hBEEF);
    settle();
    n_cmp++; if (wb_stall !== 1'b1 || ll_o_ready !== 2'b00) begin n_bad++; $display("FAIL full_flags: got stall=%b ready=%b want 1/00", wb_stall, ll_o_ready); end
    n_cmp++; if (wb_rd !== 5'd11 || wb_data !== 64'hF000) begin n_bad++; $display("FAIL full_head: got rd=%0d data=%h want 11/f000", wb_rd, wb_data); end
    snap = m_instret;
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (wb_instret !== snap) begin n_bad++; $display("FAIL stall_instret: got %0d want %0d", wb_instret, snap); end
    for (int i = 1; i < DEPTH; i++) begin
      if (i > 1) settle();
      n_cmp++; if (wb_stall !== 1'b0 || wb_wen !== 1'b1 || wb_rd !== 5'(11 + i) || wb_data !== 64'(32'hF000 + i)) begin n_bad++; $display("FAIL drain_%0d: got stall=%b wen=%b rd=%0d data=%h want 0/1/%0d/%h", i, wb_stall, wb_wen, wb_rd, wb_data, 11 + i, 32'hF000 + i); end
      tick();
    end
    settle();
    n_cmp++; if (wb_wen !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", wb_wen); end
    tick();
  endtask

  task automatic test_wrap();
    logic [63:0] vals [10];
    clear_inputs();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        vals[i] = {$urandom, $urandom};
        set_ll(0, 1'b1, 5'(i + 1), vals[i]);
      end else begin
        set_ll(0, 1'b0, 5'd0, 64'h0);
      end
      settle();
      if (i == 0) begin
        n_cmp++; if (wb_wen !== 1'b0) begin n_bad++; $display("FAIL wrap_first: got wen=%b want 0", wb_wen); end
      end else begin
        n_cmp++; if (wb_wen !== 1'b1 || wb_rd !== 5'(i) || wb_data !== vals[i-1]) begin n_bad++; $display("FAIL wrap_%0d: got wen=%b rd=%0d data=%h want 1/%0d/%h", i, wb_wen, wb_rd, wb_data, i, vals[i-1]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_pipe(12'h000, 3'd0, 64'h99, 64'h0, 64'h0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      set_ll(0, 1'b1, 5'(20 + i), 64'(i));
      settle(); tick();
    end
    rst = 1'b1;
    settle();
    n_cmp++; if (wb_wen !== 1'b0 || ll_o_ready !== 2'b00 || wb_stall !== 1'b0) begin n_bad++; $display("FAIL midrst_hold: got wen=%b ready=%b stall=%b want 0/00/0", wb_wen, ll_o_ready, wb_stall); end
    tick();
    rst = 1'b0;
    clear_inputs();
    settle();
    n_cmp++; if (wb_wen !== 1'b0 || wb_stall !== 1'b0 || wb_instret !== 64'd0) begin n_bad++; $display("FAIL midrst_after: got wen=%b stall=%b instret=%0d want 0/0/0", wb_wen, wb_stall, wb_instret); end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] op;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 2))
        0:       op = 12'h000;
        1:       op = 12'h100;
        default: op = 12'h200;
      endcase
      regW_i_valid       = $urandom_range(0, 3) != 0;
      regW_i_opcode_info = op;
      regW_i_funct3      = 3'($urandom);
      regW_i_alu_result  = {$urandom, $urandom};
      regW_i_memdata     = {$urandom, $urandom};
      regW_i_pc          = {$urandom, $urandom};
      regW_i_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      regW_i_reg_wen     = $urandom_range(0, 4) != 0;
      for (int k = 0; k < NUM_LL; k++)
        set_ll(k, $urandom_range(0, 2) == 0,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
               {$urandom, $urandom});
      settle();
      n_cmp++; if (wb_stall !== e_stall || ll_o_ready !== e_ready) begin n_bad++; $display("FAIL rnd_ctl_%0d: got stall=%b ready=%b want %b/%b", c, wb_stall, ll_o_ready, e_stall, e_ready); end
      n_cmp++; if (wb_wen !== e_wen || (e_wen && (wb_rd !== e_rd || wb_data !== e_data))) begin n_bad++; $display("FAIL rnd_port_%0d: got wen=%b rd=%0d data=%h want %b/%0d/%h", c, wb_wen, wb_rd, wb_data, e_wen, e_rd, e_data); end
      n_cmp++; if (!rst && wb_instret !== m_instret) begin n_bad++; $display("FAIL rnd_instret_%0d: got %0d want %0d", c, wb_instret, m_instret); end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_jal();
    test_collision();
    test_fill();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
